// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps minterms 0..15 on vec, samples s_in after
// SETTLE cycles per minterm, and builds a 16-bit truth table.
// Ports: clk, rst_n (async low), start, s_in -> vec, busy, done,
//   table_out, match, mismatch_cnt. Optional COMPARE_EN adds the
//   EXPECTED comparison; without it match/mismatch_cnt are tied to 0.
module truth_table_scanner #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h1894
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_in,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match,
  output logic [4:0]  mismatch_cnt
);

  localparam logic [3:0] SET = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] table_q, table_d;
  logic        accept;
  logic        sample;

  assign accept = (state_q == IDLE) && start;
  assign sample = (state_q == RUN) && (cnt_q == SET);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = 4'd0;
          cnt_d   = 4'd0;
          table_d = 16'h0000;
        end
      end
      RUN: begin
        if (cnt_q == SET) begin
          table_d[m_q] = s_in;
          if (m_q == 4'd15) begin
            state_d = DONE;
          end else begin
            m_d   = m_q + 4'd1;
            cnt_d = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= 4'd0;
      cnt_q   <= 4'd0;
      table_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
    end
  end

  assign vec       = (state_q == RUN) ? m_q : 4'd0;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign table_out = table_q;

`ifdef COMPARE_EN
  logic       match_q, match_d;
  logic [4:0] mcnt_q, mcnt_d;

  // match is resolved on the final sample so it is already valid
  // in the DONE cycle.
  always_comb begin
    match_d = match_q;
    mcnt_d  = mcnt_q;
    if (accept) begin
      match_d = 1'b0;
      mcnt_d  = 5'd0;
    end else if (sample) begin
      if (s_in != EXPECTED[m_q]) begin
        mcnt_d = mcnt_q + 5'd1;
      end
      if (m_q == 4'd15) begin
        match_d = (mcnt_d == 5'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      mcnt_q  <= 5'd0;
    end else begin
      match_q <= match_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign match        = match_q;
  assign mismatch_cnt = mcnt_q;
`else
  logic unused_cmp;
  assign unused_cmp   = ^{EXPECTED, accept, sample};
  assign match        = 1'b0;
  assign mismatch_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: vector table plus random device tables,
// with start-while-busy and mid-scan reset sequences.
module tb_truth_table_scanner;

  localparam int S = 2;
  localparam logic [15:0] EXP = 16'h1894;
  localparam int RUNC = 16 * (S + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_in;
  logic [3:0]  vec;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        match;
  logic [4:0]  mismatch_cnt;
  logic [15:0] dev_tbl = 16'h0000;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Device under scan: a lookup of the current vector.
  assign s_in = dev_tbl[vec];

  truth_table_scanner #(
    .SETTLE(S),
    .EXPECTED(EXP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .s_in(s_in),
    .vec(vec),
    .busy(busy),
    .done(done),
    .table_out(table_out),
    .match(match),
    .mismatch_cnt(mismatch_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] dev;
    logic [15:0] e_tbl;
    logic        e_match;
    logic [4:0]  e_cnt;
  } vec_t;

  task automatic scan(input string nm, input logic [15:0] dev,
                      input logic [15:0] e_tbl, input logic e_match,
                      input logic [4:0] e_cnt, input bit poke);
    int vec_err = 0;
    int busy_err = 0;
    int tie_err = 0;
    int dones = 0;
    int done_c = 0;
    logic [15:0] t = 16'h0;
    logic m = 1'b0;
    logic [4:0] mc = 5'd0;
    logic eb;
    logic [3:0] ev;
`ifndef COMPARE_EN
    e_match = 1'b0;
    e_cnt = 5'd0;
`endif
    dev_tbl = dev;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= RUNC + 6; c++) begin
      @(negedge clk);
      eb = (c <= RUNC);
      ev = eb ? 4'((c - 1) / (S + 1)) : 4'd0;
      if (vec !== ev) vec_err++;
      if (busy !== eb) busy_err++;
      if (match !== 1'b0 || mismatch_cnt !== 5'd0) tie_err++;
      if (done === 1'b1) begin
        dones++;
        done_c = c;
        t = table_out;
        m = match;
        mc = mismatch_cnt;
      end
      if (poke && c == 10) start = 1'b1;
      if (poke && c == 11) start = 1'b0;
    end
    chk({nm, ".vec_seq_errs"}, vec_err, 0);
    chk({nm, ".busy_seq_errs"}, busy_err, 0);
    chk({nm, ".done_pulses"}, dones, 1);
    chk({nm, ".done_cycle"}, done_c, RUNC + 1);
    chk({nm, ".table_at_done"}, t, e_tbl);
    chk({nm, ".match_at_done"}, m, e_match);
    chk({nm, ".mcnt_at_done"}, mc, e_cnt);
    chk({nm, ".table_held"}, table_out, e_tbl);
    chk({nm, ".match_held"}, match, e_match);
    chk({nm, ".mcnt_held"}, mismatch_cnt, e_cnt);
`ifndef COMPARE_EN
    chk({nm, ".tied_zero_errs"}, tie_err, 0);
`endif
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".vec"}, vec, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".table"}, table_out, 0);
    chk({nm, ".match"}, match, 0);
    chk({nm, ".mcnt"}, mismatch_cnt, 0);
  endtask

  initial begin
    vec_t tv[4];
    logic [15:0] r;
    tv[0] = '{"nominal", 16'h1894, 16'h1894, 1'b1, 5'd0};
    tv[1] = '{"stuck0",  16'h0000, 16'h0000, 1'b0, 5'd5};
    tv[2] = '{"stuck1",  16'hFFFF, 16'hFFFF, 1'b0, 5'd11};
    tv[3] = '{"flip0",   16'h1895, 16'h1895, 1'b0, 5'd1};

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      scan(tv[i].name, tv[i].dev, tv[i].e_tbl, tv[i].e_match,
           tv[i].e_cnt, 1'b0);
    end

    scan("busy_start", 16'h1894, 16'h1894, 1'b1, 5'd0, 1'b1);

    // Reset in cycle 20 of a stuck-at-1 scan must clear at once.
    dev_tbl = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    chk("pre_reset.table_nonzero", (table_out != 16'h0), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    scan("after_reset", 16'h1894, 16'h1894, 1'b1, 5'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      if (i == 0) r = EXP ^ 16'h8000;
      scan($sformatf("rand%0d", i), r, r, (r == EXP),
           5'($countones(r ^ EXP)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
